mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit feeding the HI/LO registers of the
//  multicycle CPU datapath. Control unit pulses start with operands from A/B; the unit
//  iterates one bit per cycle, then loads hi/lo and pulses done. hi/lo drive MemToReg
//  (MFHI/MFLO). Flags divide-by-zero for the exception path (vector 255).
// PARAMETERS
//  WIDTH   32   operand width; hi and lo are WIDTH bits each; even, >= 4
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      launch operation; sampled only in IDLE
//  op        in   2      00 MULT, 01 DIV, 10 MULTU, 11 DIVU (op[0]: 0 mul / 1 div)
//  a         in   WIDTH  multiplicand / dividend (RegA)
//  b         in   WIDTH  multiplier / divisor (RegB)
//  busy      out  1      high from the cycle after start is accepted until done
//  done      out  1      one-cycle pulse: result (or div_zero) valid
//  div_zero  out  1      one-cycle pulse coincident with done on divide by zero
//  hi        out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  lo        out  WIDTH  MULT: product[W-1:0];  DIV: quotient
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. Reset (any time, incl. mid-op):
//    state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, internal counter/regs cleared.
//  - FSM: IDLE -> RUN (start=1, divisor nonzero or multiply) -> FIN -> IDLE;
//    IDLE -> ZERO (start=1, divide, b==0) -> IDLE.
//  - Start accepted at edge k: operands captured (signed ops convert to magnitudes,
//    result sign recorded). RUN performs WIDTH iterations (edges k+1..k+WIDTH):
//    multiply = shift-add on magnitudes; divide = restoring, one quotient bit/cycle.
//  - FIN: sign-correct result, load hi/lo, done=1 for exactly one cycle
//    (cycle after edge k+WIDTH+1). busy=1 in RUN and FIN, 0 in IDLE/ZERO.
//  - Latency start-edge to done: WIDTH+1 cycles (33 for WIDTH=32). Next start may be
//    accepted in the cycle done is high? No: FIN returns to IDLE; start accepted from
//    the cycle after done onward.
//  - start while busy: ignored, no effect on operands or timing.
//  - Signed divide: quotient truncates toward zero; remainder takes sign of dividend.
//    MIN / -1: lo=MIN (wraps), hi=0, no flag.
//  - Divide by zero: no iteration; ZERO state gives done=1, div_zero=1 the cycle after
//    the start edge; hi/lo keep previous values.
//  - hi/lo change only in FIN or on reset; held stable otherwise.
//  - op/a/b ignored except at the accepting edge.
// CONFIGURATION
//  MULT_DIV_UNSIGNED_EN defined: op[1]=1 selects unsigned operation (MULTU/DIVU),
//    operands taken as magnitudes, no sign correction.
//  Not defined: op[1] ignored; all operations signed; unsigned logic not synthesised.
// TESTING (WIDTH=32)
//  MULT a=7 b=FFFFFFFD -> done 33 cycles after start; hi=FFFFFFFF lo=FFFFFFEB.
//  DIV a=FFFFFFF9 b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIV a=80000000 b=FFFFFFFF ->
//    lo=80000000 hi=0, div_zero=0.
//  DIV a=5 b=0 after prior result hi=1 lo=2 -> next cycle done=1 div_zero=1;
//    hi=1 lo=2 unchanged; busy never asserted.
//  start pulsed again at cycle 10 of a MULT, new operands -> ignored; original result
//    at cycle 33; reset low at cycle 20 of a DIV -> outputs 0 immediately, no done.
//  MULTU a=FFFFFFFF b=2: with MULT_DIV_UNSIGNED_EN -> hi=1 lo=FFFFFFFE;
//    without -> treated signed: hi=FFFFFFFF lo=FFFFFFFE.
//  Back-to-back: start on the cycle after done -> accepted, second done 33 later.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit. It produces HI/LO results and flags
// divide by zero.
// Multiply uses shift-add on the operand magnitudes. Divide is restoring
// division and produces one quotient bit per cycle. The sign is fixed up
// in FIN.
// Optional feature: define MULT_DIV_UNSIGNED_EN so that op[1] selects an
// unsigned operation (MULTU/DIVU).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN, ZERO} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] acc_reg;       // running high product / partial remainder
    logic [WIDTH-1:0] mq_reg;        // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] opnd_reg;      // multiplicand or divisor magnitude
    logic             is_div_reg;
    logic             neg_q_reg;     // negate product or quotient
    logic             neg_r_reg;     // negate remainder (sign of dividend)
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             done_reg, div_zero_reg;

    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept, zero_div;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef MULT_DIV_UNSIGNED_EN
    assign signed_op = ~op[1];
`else
    // op[1] has no meaning when only signed operations exist
    logic op_unused;
    assign op_unused = op[1];
    assign signed_op = 1'b1;
`endif

    // Operand magnitudes, acceptance, and one iteration step for each algorithm
    always_comb begin
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;
        accept    = (state_reg == IDLE) && start && !done_reg;
        zero_div  = op[0] && (b == '0);
        addend    = mq_reg[0] ? opnd_reg : {WIDTH{1'b0}};
        mul_sum   = {1'b0, acc_reg} + {1'b0, addend};
        div_shift = {acc_reg, mq_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_reg};
        prod      = {acc_reg, mq_reg};
        prod_fix  = neg_q_reg ? (~prod + 1'b1) : prod;
        quo_fix   = neg_q_reg ? (~mq_reg + 1'b1) : mq_reg;
        rem_fix   = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;
    end

    // Next-state logic and busy decode
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            IDLE: if (accept) state_next = zero_div ? ZERO : RUN;
            RUN: begin
                busy = 1'b1;
                if (count_reg == CW'(WIDTH - 1)) state_next = FIN;
            end
            FIN: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            ZERO:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Operand capture, iteration, and result load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg    <= '0;
            acc_reg      <= '0;
            mq_reg       <= '0;
            opnd_reg     <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            case (state_reg)
                IDLE: if (accept) begin
                    if (zero_div) begin
                        done_reg     <= 1'b1;
                        div_zero_reg <= 1'b1;
                    end else begin
                        count_reg  <= '0;
                        acc_reg    <= '0;
                        is_div_reg <= op[0];
                        neg_q_reg  <= a_neg ^ b_neg;
                        neg_r_reg  <= a_neg;
                        mq_reg     <= op[0] ? a_mag : b_mag;
                        opnd_reg   <= op[0] ? b_mag : a_mag;
                    end
                end
                RUN: begin
                    count_reg <= count_reg + CW'(1);
                    if (is_div_reg) begin
                        // A negative trial means the divisor does not fit, so restore
                        if (!div_trial[WIDTH]) begin
                            acc_reg <= div_trial[WIDTH-1:0];
                            mq_reg  <= {mq_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_reg <= div_shift[WIDTH-1:0];
                            mq_reg  <= {mq_reg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_reg <= mul_sum[WIDTH:1];
                        mq_reg  <= {mul_sum[0], mq_reg[WIDTH-1:1]};
                    end
                end
                FIN: begin
                    done_reg <= 1'b1;
                    if (is_div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule
